// File: rtl/pmem_arbiter.sv
// Arbitrates the shared line-wide physical memory port between the I-side and D-side
// cache miss paths: one transaction in flight, response steered back to its owner.
`timescale 1ns/1ps

module pmem_arbiter #(
   parameter int ROUND_ROBIN = 1,
   parameter int ADDR_W      = 32,
   parameter int LINE_W      = 256
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,

   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,

   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;   // 0 = I won last, 1 = D won last
   logic                op_write_q, op_write_d;
   logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
   logic [LINE_W-1:0]   op_wdata_q, op_wdata_d;

   logic req_i, req_d;
   logic grant_i, grant_d;

   assign req_i = i_read | i_write;
   assign req_d = d_read | d_write;

   // On a tie, round-robin hands the grant to the side that lost last time;
   // fixed priority leaves grant_i low so D always wins.
   assign grant_i = req_i & (~req_d | ((ROUND_ROBIN != 0) & last_grant_q));
   assign grant_d = req_d & ~grant_i;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can leave
      // one unassigned and infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_write_d   = op_write_q;
      op_addr_d    = op_addr_q;
      op_wdata_d   = op_wdata_q;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      busy         = 1'b0;

      case (state_q)
         IDLE: begin
            // A simultaneous read+write from one side is treated as a write.
            if (grant_i) begin
               state_d      = SERVE_I;
               last_grant_d = 1'b0;
               op_write_d   = i_write;
               op_addr_d    = i_address;
               op_wdata_d   = i_wdata;
            end else if (grant_d) begin
               state_d      = SERVE_D;
               last_grant_d = 1'b1;
               op_write_d   = d_write;
               op_addr_d    = d_address;
               op_wdata_d   = d_wdata;
            end
         end

         SERVE_I: begin
            busy       = 1'b1;
            pmem_read  = ~op_write_q;
            pmem_write = op_write_q;
            i_resp     = pmem_resp;
            if (pmem_resp) state_d = IDLE;
         end

         SERVE_D: begin
            busy       = 1'b1;
            pmem_read  = ~op_write_q;
            pmem_write = op_write_q;
            d_resp     = pmem_resp;
            if (pmem_resp) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // Address and data come straight from the latches, so they hold steady for the
   // whole transaction whatever the requesters do with their inputs.
   assign pmem_address = op_addr_q;
   assign pmem_wdata   = op_wdata_q;
   assign i_rdata      = pmem_rdata;
   assign d_rdata      = pmem_rdata;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register here
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op_write_q   <= 1'b0;
         // NOTE: the wide address/line latches are reset as well, because they drive
         // pmem_address/pmem_wdata directly and those must read zero after reset.
         op_addr_q    <= '0;
         op_wdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_write_q   <= op_write_d;
         op_addr_q    <= op_addr_d;
         op_wdata_q   <= op_wdata_d;
      end
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: requester and memory models drive both a round-robin
// and a fixed-priority instance; a monitor checks grants, held strobes and responses.
`timescale 1ns/1ps

module tb_pmem_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      bit            hold_next;   // present the next queued command without a gap cycle
      bit            mut;         // scramble address/wdata mid-transaction
   } cmd_t;

   typedef struct {
      bit            side;        // 0 = I, 1 = D
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
      bit            chk_lat;
   } exp_t;

   logic clk;
   logic rst;
   logic sel;   // 0 = round-robin instance observed, 1 = fixed-priority instance

   logic          rq_rd    [2];
   logic          rq_wr    [2];
   logic [AW-1:0] rq_addr  [2];
   logic [LW-1:0] rq_wdata [2];

   logic          i_read, i_write, d_read, d_write;
   logic [AW-1:0] i_address, d_address;
   logic [LW-1:0] i_wdata, d_wdata;
   logic          pmem_resp;
   logic [LW-1:0] pmem_rdata;

   assign i_read    = rq_rd[0];
   assign i_write   = rq_wr[0];
   assign i_address = rq_addr[0];
   assign i_wdata   = rq_wdata[0];
   assign d_read    = rq_rd[1];
   assign d_write   = rq_wr[1];
   assign d_address = rq_addr[1];
   assign d_wdata   = rq_wdata[1];

   logic          rr_i_resp, rr_d_resp, rr_pmem_read, rr_pmem_write, rr_busy;
   logic          fp_i_resp, fp_d_resp, fp_pmem_read, fp_pmem_write, fp_busy;
   logic [LW-1:0] rr_i_rdata, rr_d_rdata, rr_pmem_wdata;
   logic [LW-1:0] fp_i_rdata, fp_d_rdata, fp_pmem_wdata;
   logic [AW-1:0] rr_pmem_address, fp_pmem_address;

   logic          i_resp, d_resp, pmem_read, pmem_write, busy;
   logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
   logic [AW-1:0] pmem_address;

   pmem_arbiter #(.ROUND_ROBIN(1), .ADDR_W(AW), .LINE_W(LW)) u_rr (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_resp(rr_i_resp), .i_rdata(rr_i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(rr_d_resp), .d_rdata(rr_d_rdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .pmem_read(rr_pmem_read), .pmem_write(rr_pmem_write),
      .pmem_address(rr_pmem_address), .pmem_wdata(rr_pmem_wdata),
      .busy(rr_busy)
   );

   pmem_arbiter #(.ROUND_ROBIN(0), .ADDR_W(AW), .LINE_W(LW)) u_fp (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_resp(fp_i_resp), .i_rdata(fp_i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(fp_d_resp), .d_rdata(fp_d_rdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .pmem_read(fp_pmem_read), .pmem_write(fp_pmem_write),
      .pmem_address(fp_pmem_address), .pmem_wdata(fp_pmem_wdata),
      .busy(fp_busy)
   );

   assign i_resp       = sel ? fp_i_resp       : rr_i_resp;
   assign d_resp       = sel ? fp_d_resp       : rr_d_resp;
   assign i_rdata      = sel ? fp_i_rdata      : rr_i_rdata;
   assign d_rdata      = sel ? fp_d_rdata      : rr_d_rdata;
   assign pmem_read    = sel ? fp_pmem_read    : rr_pmem_read;
   assign pmem_write   = sel ? fp_pmem_write   : rr_pmem_write;
   assign pmem_address = sel ? fp_pmem_address : rr_pmem_address;
   assign pmem_wdata   = sel ? fp_pmem_wdata   : rr_pmem_wdata;
   assign busy         = sel ? fp_busy         : rr_busy;

   int   n_cmp, n_err, cyc;
   int   start_cyc [2];
   int   act_cyc   [2];
   bit   active    [2];
   bit   seen      [2];
   cmd_t cur_cmd   [2];
   cmd_t i_q[$], d_q[$];
   exp_t exp_q[$];
   exp_t cur;
   bit   inflight;
   logic busy_prev;
   int   mem_lat, mem_cnt;
   bit   mem_force;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [LW-1:0] rdata_of(input logic [AW-1:0] a);
      if (a == 32'h0000_1000) return {32{8'hAA}};
      return {8{a ^ 32'hC0DE_0000}};
   endfunction

   // Memory model: answers after mem_lat strobe cycles; mem_force injects one stray pulse.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      mem_cnt    = 0;
      forever begin
         @(posedge clk);
         #1;
         pmem_resp = 1'b0;
         if (mem_force) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {LW{1'b1}};
            mem_force  = 1'b0;
         end else if ((pmem_read || pmem_write) && !rst) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
               pmem_resp  = 1'b1;
               pmem_rdata = rdata_of(pmem_address);
               mem_cnt    = 0;
            end
         end else begin
            mem_cnt = 0;
         end
      end
   end

   function automatic int q_size(input int s);
      return (s == 0) ? i_q.size() : d_q.size();
   endfunction

   task automatic drive_idle(input int s);
      rq_rd[s]    = 1'b0;
      rq_wr[s]    = 1'b0;
      rq_addr[s]  = '0;
      rq_wdata[s] = '0;
   endtask

   task automatic load(input int s);
      cmd_t c;
      if (s == 0) c = i_q.pop_front();
      else        c = d_q.pop_front();
      cur_cmd[s]   = c;
      rq_rd[s]     = c.rd;
      rq_wr[s]     = c.wr;
      rq_addr[s]   = c.addr;
      rq_wdata[s]  = c.wdata;
      active[s]    = 1'b1;
      seen[s]      = 1'b0;
      act_cyc[s]   = 0;
      start_cyc[s] = cyc;
   endtask

   task automatic abort_side(input int s);
      active[s] = 1'b0;
      seen[s]   = 1'b0;
      drive_idle(s);
   endtask

   // Requester: holds a command until its resp, then drops it (or chains the next one).
   task automatic requester(input int s);
      forever begin
         @(posedge clk);
         #1;
         if (active[s] && seen[s]) begin
            active[s] = 1'b0;
            seen[s]   = 1'b0;
            drive_idle(s);
            if (cur_cmd[s].hold_next && q_size(s) > 0) load(s);
         end else if (active[s]) begin
            act_cyc[s]++;
            if (cur_cmd[s].mut && act_cyc[s] == 2) begin
               rq_addr[s]  = rq_addr[s] + 32'h1000;
               rq_wdata[s] = ~rq_wdata[s];
            end
         end else if (q_size(s) > 0) begin
            load(s);
         end
      end
   endtask

   initial requester(0);
   initial requester(1);

   initial begin
      forever begin
         @(negedge clk);
         if (i_resp === 1'b1 && active[0]) seen[0] = 1'b1;
         if (d_resp === 1'b1 && active[1]) seen[1] = 1'b1;
      end
   end

   // Monitor: pops the scoreboard on each new grant, checks the hold, then the response.
   initial begin
      busy_prev = 1'b0;
      inflight  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (busy === 1'b1 && busy_prev !== 1'b1) begin
               check("resp_before_next_grant", LW'(inflight), LW'(1'b0));
               if (exp_q.size() == 0) begin
                  check("unexpected_grant", LW'(busy), LW'(1'b0));
               end else begin
                  cur      = exp_q.pop_front();
                  inflight = 1'b1;
                  check("grant_strobes", LW'({pmem_read, pmem_write}), LW'({~cur.wr, cur.wr}));
                  check("grant_addr", LW'(pmem_address), LW'(cur.addr));
                  if (cur.wr) check("grant_wdata", pmem_wdata, cur.wdata);
                  if (cur.chk_lat) check("grant_latency", LW'(cyc - start_cyc[cur.side]), LW'(1));
               end
            end else if (busy === 1'b1 && inflight) begin
               check("hold_strobes", LW'({pmem_read, pmem_write}), LW'({~cur.wr, cur.wr}));
               check("hold_addr", LW'(pmem_address), LW'(cur.addr));
               if (cur.wr) check("hold_wdata", pmem_wdata, cur.wdata);
            end
            if (i_resp === 1'b1 || d_resp === 1'b1) begin
               if (!inflight) begin
                  check("spurious_resp", LW'({i_resp, d_resp}), LW'(2'b00));
               end else begin
                  check("resp_side", LW'({i_resp, d_resp}), LW'(cur.side ? 2'b01 : 2'b10));
                  if (!cur.wr) check("resp_rdata", cur.side ? d_rdata : i_rdata, cur.rdata);
                  inflight = 1'b0;
               end
            end
         end
         busy_prev = busy;
      end
   end

   task automatic push_cmd(input int s, input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd, input bit hold, input bit mut);
      cmd_t c;
      c.rd = rd; c.wr = wr; c.addr = a; c.wdata = wd; c.hold_next = hold; c.mut = mut;
      if (s == 0) i_q.push_back(c);
      else        d_q.push_back(c);
   endtask

   task automatic push_exp(input bit side, input logic wr, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd, input bit chk_lat);
      exp_t e;
      e.side = side; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rdata_of(a);
      e.chk_lat = chk_lat;
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         done = (i_q.size() == 0) && (d_q.size() == 0) && !active[0] && !active[1] &&
                (exp_q.size() == 0) && !inflight && (busy === 1'b0);
      end
      check("drain_done", LW'(done), LW'(1'b1));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      abort_side(0);
      abort_side(1);
      inflight = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ctrl", LW'({busy, pmem_read, pmem_write, i_resp, d_resp}), LW'(5'b0));
      check("rst_addr", LW'(pmem_address), '0);
      check("rst_wdata", pmem_wdata, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bit got;
      n_cmp = 0; n_err = 0;
      rst = 1'b1; sel = 1'b0;
      mem_lat = 3; mem_force = 1'b0;
      for (int s = 0; s < 2; s++) begin
         drive_idle(s);
         active[s] = 1'b0; seen[s] = 1'b0; act_cyc[s] = 0; start_cyc[s] = 0;
      end

      do_reset();

      // Single I-side read, memory answers on the third strobe cycle.
      push_cmd(0, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b0, 1'b0);
      push_exp(1'b0, 1'b0, 32'h0000_1000, '0, 1'b1);
      drain(40);

      // A stray pmem_resp while idle must produce nothing.
      mem_force = 1'b1;
      @(negedge clk);
      check("idle_resp", LW'({i_resp, d_resp, busy}), LW'(3'b000));
      @(negedge clk);
      check("idle_after", LW'(busy), LW'(1'b0));

      // D-side write whose requester changes address/data mid-transaction.
      mem_lat = 4;
      push_cmd(1, 1'b0, 1'b1, 32'h0000_2000, {32{8'h55}}, 1'b0, 1'b1);
      push_exp(1'b1, 1'b1, 32'h0000_2000, {32{8'h55}}, 1'b1);
      drain(40);

      // Read and write together from I: write wins.
      mem_lat = 3;
      push_cmd(0, 1'b1, 1'b1, 32'h0000_4000, {8{32'h0123_4567}}, 1'b0, 1'b0);
      push_exp(1'b0, 1'b1, 32'h0000_4000, {8{32'h0123_4567}}, 1'b1);
      drain(40);

      // Round-robin, both sides requesting back to back: I, D, I, D.
      do_reset();
      push_cmd(0, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b1, 1'b0);
      push_cmd(0, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b0, 1'b0);
      push_cmd(1, 1'b1, 1'b0, 32'h0000_2000, '0, 1'b1, 1'b0);
      push_cmd(1, 1'b1, 1'b0, 32'h0000_2000, '0, 1'b0, 1'b0);
      push_exp(1'b0, 1'b0, 32'h0000_1000, '0, 1'b1);
      push_exp(1'b1, 1'b0, 32'h0000_2000, '0, 1'b0);
      push_exp(1'b0, 1'b0, 32'h0000_1000, '0, 1'b0);
      push_exp(1'b1, 1'b0, 32'h0000_2000, '0, 1'b0);
      drain(100);

      // Fixed priority: D keeps winning while it requests, then I.
      sel = 1'b1;
      do_reset();
      push_cmd(1, 1'b1, 1'b0, 32'h0000_2000, '0, 1'b1, 1'b0);
      push_cmd(1, 1'b1, 1'b0, 32'h0000_2100, '0, 1'b1, 1'b0);
      push_cmd(1, 1'b1, 1'b0, 32'h0000_2200, '0, 1'b0, 1'b0);
      push_cmd(0, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 32'h0000_2000, '0, 1'b1);
      push_exp(1'b1, 1'b0, 32'h0000_2100, '0, 1'b0);
      push_exp(1'b1, 1'b0, 32'h0000_2200, '0, 1'b0);
      push_exp(1'b0, 1'b0, 32'h0000_1000, '0, 1'b0);
      drain(100);

      // Reset two cycles into a D-side read abandons it; a following tie goes to I.
      sel = 1'b0;
      do_reset();
      mem_lat = 20;
      push_cmd(1, 1'b1, 1'b0, 32'h0000_5000, '0, 1'b0, 1'b0);
      push_exp(1'b1, 1'b0, 32'h0000_5000, '0, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = (busy === 1'b1);
      end
      check("abort_busy_seen", LW'(got), LW'(1'b1));
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      abort_side(1);
      inflight = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_outputs", LW'({pmem_read, busy, d_resp}), LW'(3'b000));
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_lat = 3;
      @(negedge clk);
      push_cmd(0, 1'b1, 1'b0, 32'h0000_1000, '0, 1'b0, 1'b0);
      push_cmd(1, 1'b1, 1'b0, 32'h0000_2000, '0, 1'b0, 1'b0);
      push_exp(1'b0, 1'b0, 32'h0000_1000, '0, 1'b1);
      push_exp(1'b1, 1'b0, 32'h0000_2000, '0, 1'b0);
      drain(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 256-bit physical-memory port between the I-side and D-side line-fill/writeback paths of the cache hierarchy.
- Sits between the L1 instruction/data cache miss ports and `pmem_*` at the top level.
- Grants one requester at a time, latches its request, and holds the downstream read/write until `pmem_resp`.
- Steers the response back to the granted requester. Arbitration is round-robin, or fixed priority by parameter.

Parameters:
- `ROUND_ROBIN`, default 1: 1 = alternate the grant on contention; 0 = D-side always wins on contention.
- `ADDR_W`, default 32: physical address width.
- `LINE_W`, default 256: cache line width in bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_read`  in  1  I-side line read request, held until `i_resp`.
- `i_write`  in  1  I-side line write request, held until `i_resp`.
- `i_address`  in  ADDR_W  I-side line address.
- `i_wdata`  in  LINE_W  I-side write line.
- `i_resp`  out  1  I-side completion, one cycle.
- `i_rdata`  out  LINE_W  I-side read line, valid with `i_resp`.
- `d_read`  in  1  D-side line read request.
- `d_write`  in  1  D-side line write request.
- `d_address`  in  ADDR_W  D-side line address.
- `d_wdata`  in  LINE_W  D-side write line.
- `d_resp`  out  1  D-side completion, one cycle.
- `d_rdata`  out  LINE_W  D-side read line, valid with `d_resp`.
- `pmem_resp`  in  1  memory completion.
- `pmem_rdata`  in  LINE_W  memory read line.
- `pmem_read`  out  1  memory read strobe.
- `pmem_write`  out  1  memory write strobe.
- `pmem_address`  out  ADDR_W  memory address.
- `pmem_wdata`  out  LINE_W  memory write line.
- `busy`  out  1  high while a transaction is outstanding.

Behaviour:
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`.
- Additional registers:
  - `last_grant` (0 = I, 1 = D).
  - Latched `op_write`, `op_addr`, `op_wdata`.
- Reset (sync, `rst`=1 at an edge):
  - State `IDLE`, `last_grant`=1 (so I-side wins the first tie), latches cleared.
  - All outputs are 0 the cycle after: `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `i_resp`, `d_resp`, `busy`.
  - A reset during `SERVE_*` abandons the transaction: strobes drop the next cycle and no resp is issued.
- `IDLE`:
  - `req_i` = `i_read` | `i_write`; `req_d` = `d_read` | `d_write`.
  - Only one request: grant it.
  - Both requesting with `ROUND_ROBIN`=1: grant the side opposite `last_grant`.
  - Both requesting with `ROUND_ROBIN`=0: grant D.
  - On grant at edge N:
    - Latch address, wdata and `op_write` from the granted side. If read and write are both asserted, the write takes precedence.
    - Update `last_grant` and move to `SERVE_x`.
- `SERVE_x`:
  - `pmem_read` = !`op_write`; `pmem_write` = `op_write`.
  - `pmem_address` = `op_addr`; `pmem_wdata` = `op_wdata`.
  - Outputs are registered/state-decoded: first asserted in cycle N+1.
  - Outputs stay stable until `pmem_resp`, regardless of requester input changes.
- Completion:
  - In the cycle `pmem_resp`=1 while in `SERVE_x`, `x_resp`=1 combinationally and `x_rdata` = `pmem_rdata`.
  - Next state is `IDLE`.
  - `pmem_read`/`pmem_write` deassert at M+1.
- Returning to `IDLE`:
  - At least one `IDLE` cycle separates back-to-back transactions.
  - The requester drops its request in the cycle after its resp, so `IDLE` does not re-grant it spuriously.
- Non-granted side:
  - Its resp stays 0.
  - Its `rdata` is don't-care; drive `pmem_rdata` to both.
- `pmem_resp` while in `IDLE`: ignored.
- `busy` = (state != `IDLE`).
- Latency: request sampled at edge N, memory strobe in cycle N+1, resp in the same cycle as `pmem_resp`. Minimum request-to-resp is 1 cycle after the grant edge.
- Fairness: with `ROUND_ROBIN`=1 and both sides continuously requesting, grants strictly alternate I, D, I, D.

Test Plan:
1. Reset, then `i_read`=1 with `i_address`=0x0000_1000. Required:
   - `pmem_read`=1 with `pmem_address`=0x1000 the next cycle.
   - Memory asserts `pmem_resp` 3 cycles later with `rdata`=0xAA..AA.
   - `i_resp`=1, `i_rdata`=0xAA..AA for exactly 1 cycle; `d_resp` stays 0.
2. `d_write`=1 with `d_address`=0x2000, `d_wdata`=0x55..55; change `d_address` to 0x3000 mid-transaction. Required:
   - `pmem_write`=1, `pmem_address`=0x2000, `wdata`=0x55..55, held until `pmem_resp`.
   - `d_resp` pulses once.
3. `ROUND_ROBIN`=1, `i_read` and `d_read` asserted on the same cycle after reset, each re-requested after its resp. Required:
   - Grant order I, D, I, D.
   - `pmem_address` alternates between 0x1000 and 0x2000.
4. `ROUND_ROBIN`=0, both requesting continuously. Required:
   - D is granted every time until `d_read` drops, then I is granted.
5. `i_read`=1 and `i_write`=1 together. Required: `pmem_write`=1 and `pmem_read`=0.
6. `rst`=1 asserted two cycles into a D-side read, before `pmem_resp`. Required:
   - Next cycle `pmem_read`=0, `busy`=0, no `d_resp`.
   - A subsequent `i_read` is granted first (`last_grant` reset to 1).
